// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA OBI master bridge.
//   - bridge_state_e : drain/stop FSM encoding (RUN, DRAIN, STOPPED)
//   - DEF_*          : default geometry (one channel per CGRA column)
//   - cnt_width()    : outstanding-counter width for a given credit limit
package cgra_pkg;

  localparam int DEF_N_COL     = 4;
  localparam int DEF_N_CH      = DEF_N_COL;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_OUTST = 2;

  // Counter must hold 0..MAX_OUTST inclusive.
  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_MAX_OUTST);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STOPPED = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/cgra_obi_master_bridge_if.sv
// Signal bundle between the CGRA column master ports and the OBI bus.
// Core side is TCDM style (active-low write enable), bus side is OBI.
// Handshake: an address phase completes in a cycle where req and gnt are
// both high; once req is raised it stays raised with stable address-phase
// signals until gnt. A response is a single-cycle rvalid pulse carrying
// rdata, with no back-pressure.
// Modports:
//   master - the bridge view (consumes core_*, drives bus_* requests)
//   slave  - the environment view (core master and OBI slave together)
interface cgra_obi_master_bridge_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_CH-1:0]        core_req;
  logic [N_CH*ADDR_W-1:0] core_add;
  logic [N_CH-1:0]        core_wen;
  logic [N_CH*BE_W-1:0]   core_be;
  logic [N_CH*DATA_W-1:0] core_wdata;
  logic [N_CH-1:0]        core_gnt;
  logic [N_CH*DATA_W-1:0] core_rdata;
  logic [N_CH-1:0]        core_rvalid;

  logic [N_CH-1:0]        bus_req;
  logic [N_CH*ADDR_W-1:0] bus_addr;
  logic [N_CH-1:0]        bus_we;
  logic [N_CH*BE_W-1:0]   bus_be;
  logic [N_CH*DATA_W-1:0] bus_wdata;
  logic [N_CH-1:0]        bus_gnt;
  logic [N_CH*DATA_W-1:0] bus_rdata;
  logic [N_CH-1:0]        bus_rvalid;

  modport master (
    input  core_req, core_add, core_wen, core_be, core_wdata,
    output core_gnt, core_rdata, core_rvalid,
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_gnt, bus_rdata, bus_rvalid
  );

  modport slave (
    output core_req, core_add, core_wen, core_be, core_wdata,
    input  core_gnt, core_rdata, core_rvalid,
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_gnt, bus_rdata, bus_rvalid
  );

endinterface

// File: rtl/cgra_obi_chan.sv
// One bridge channel: outstanding-transaction credit counter, OBI
// address-phase hold flag, sticky unexpected-response error and the
// optional response register.
// Optional build macro: CGRA_OBI_RSP_REG_EN registers the response path
// (one cycle of latency); otherwise the response passes straight through.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   bridge FSM is in RUN (new issues allowed)
//   core_req              core request for this channel
//   bus_gnt, bus_rvalid   OBI grant / response valid
//   bus_rdata             OBI response data
//   bus_req               OBI request to the bus
//   rsp_valid, rsp_data   response towards the core
//   cnt                   granted-but-unanswered transactions
//   err                   sticky: rvalid with nothing outstanding
//   idle                  nothing outstanding, held or buffered
module cgra_obi_chan
  import cgra_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  localparam int CNT_W    = cnt_width(MAX_OUTST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              core_req,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              err,
  output logic              idle
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic pend;
  logic can_issue;
  logic hs;
  logic rsp_busy;

  assign can_issue = (cnt < MAX_CNT) & run;
  // A request left ungranted last cycle stays up regardless of credit or
  // drain state, so the OBI address phase is never withdrawn.
  assign bus_req   = core_req & (can_issue | pend);
  assign hs        = bus_req & bus_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
      err  <= 1'b0;
    end else begin
      pend <= bus_req & ~bus_gnt;
      if (hs && !bus_rvalid) begin
        if (cnt != MAX_CNT) cnt <= cnt + ONE;
      end else if (!hs && bus_rvalid) begin
        // Same-cycle handshake + rvalid is a zero-latency response and
        // leaves the count alone; only a lone rvalid at zero is an error.
        if (cnt == '0) err <= 1'b1;
        else           cnt <= cnt - ONE;
      end
    end
  end

`ifdef CGRA_OBI_RSP_REG_EN
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= bus_rvalid;
      if (bus_rvalid) rsp_data_q <= bus_rdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_busy  = rsp_valid_q;
`else
  assign rsp_valid = bus_rvalid;
  assign rsp_data  = bus_rdata;
  assign rsp_busy  = 1'b0;
`endif

  assign idle = (cnt == '0) & ~pend & ~rsp_busy;

endmodule

// File: rtl/cgra_obi_master_bridge.sv
// N-channel bridge from CGRA column TCDM-style master ports to OBI master
// ports, with per-channel outstanding-credit limiting, OBI request hold
// and a drain/stop handshake for gating the CGRA clock.
// Optional build macro: CGRA_OBI_RSP_REG_EN (registered response path,
// implemented inside cgra_obi_chan).
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   bridge_if       core + OBI signal bundle (master modport)
//   stop_req_i      request to quiesce
//   stop_ack_o      registered; high only in STOPPED
//   err_o           per-channel sticky unexpected-response flag
//   state_o         current FSM state (debug)
//   dbg_cnt_o       per-channel outstanding counters (debug)
module cgra_obi_master_bridge
  import cgra_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  localparam int CNT_W    = cnt_width(MAX_OUTST)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  cgra_obi_master_bridge_if.master  bridge_if,
  input  logic                      stop_req_i,
  output logic                      stop_ack_o,
  output logic [N_CH-1:0]           err_o,
  output bridge_state_e             state_o,
  output logic [N_CH*CNT_W-1:0]     dbg_cnt_o
);

  bridge_state_e          state;
  logic                   run;
  logic                   all_idle;
  logic [N_CH-1:0]        bus_req_w;
  logic [N_CH-1:0]        rsp_valid_w;
  logic [N_CH*DATA_W-1:0] rsp_data_w;
  logic [N_CH*CNT_W-1:0]  cnt_w;
  logic [N_CH-1:0]        err_w;
  logic [N_CH-1:0]        idle_w;
  logic [N_CH*ADDR_W-1:0] addr_w;

  assign run = (state == RUN);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cgra_obi_chan #(
      .DATA_W    (DATA_W),
      .MAX_OUTST (MAX_OUTST)
    ) u_chan (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .run        (run),
      .core_req   (bridge_if.core_req[g]),
      .bus_gnt    (bridge_if.bus_gnt[g]),
      .bus_rvalid (bridge_if.bus_rvalid[g]),
      .bus_rdata  (bridge_if.bus_rdata[g*DATA_W +: DATA_W]),
      .bus_req    (bus_req_w[g]),
      .rsp_valid  (rsp_valid_w[g]),
      .rsp_data   (rsp_data_w[g*DATA_W +: DATA_W]),
      .cnt        (cnt_w[g*CNT_W +: CNT_W]),
      .err        (err_w[g]),
      .idle       (idle_w[g])
    );
  end

  // Address-phase fields are plain copies; only req is gated.
  assign addr_w              = bridge_if.core_add;
  assign bridge_if.bus_addr  = addr_w;
  assign bridge_if.bus_we    = ~bridge_if.core_wen;
  assign bridge_if.bus_be    = bridge_if.core_be;
  assign bridge_if.bus_wdata = bridge_if.core_wdata;
  assign bridge_if.bus_req   = bus_req_w;

  assign bridge_if.core_gnt    = bus_req_w & bridge_if.bus_gnt;
  assign bridge_if.core_rvalid = rsp_valid_w;
  assign bridge_if.core_rdata  = rsp_data_w;

  assign err_o     = err_w;
  assign dbg_cnt_o = cnt_w;
  assign state_o   = state;
  assign all_idle  = &idle_w;

  // stop_ack_o is registered alongside the state so it is exactly
  // "state == STOPPED" without a combinational path to the clock gate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      stop_ack_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop_req_i) state <= DRAIN;
        end
        DRAIN: begin
          if (!stop_req_i) begin
            state <= RUN;
          end else if (all_idle) begin
            state      <= STOPPED;
            stop_ack_o <= 1'b1;
          end
        end
        STOPPED: begin
          if (!stop_req_i) begin
            state      <= RUN;
            stop_ack_o <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          stop_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_obi_master_bridge.sv
// Self-checking bench for cgra_obi_master_bridge (default geometry).
module tb_cgra_obi_master_bridge;
  import cgra_pkg::*;

  localparam int N_CH      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 2;
  localparam int CNT_W     = 2;
  localparam int EXP_W     = DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                   stop_req;
  logic                   stop_ack;
  logic [N_CH-1:0]        err;
  bridge_state_e          state;
  logic [N_CH*CNT_W-1:0]  dbg_cnt;

  cgra_obi_master_bridge_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  cgra_obi_master_bridge #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bridge_if  (bif),
    .stop_req_i (stop_req),
    .stop_ack_o (stop_ack),
    .err_o      (err),
    .state_o    (state),
    .dbg_cnt_o  (dbg_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return dbg_cnt[ch*CNT_W +: CNT_W];
  endfunction

  // Response scoreboard: every driven rvalid pushes {ch, rdata}; every
  // core_rvalid seen pops and compares.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (bif.core_rvalid[ch]) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(ch), 64'hFF);
          end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("rsp_data", 64'({2'(ch), bif.core_rdata[ch*DATA_W +: DATA_W]}), 64'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input int ch, input logic req, input logic wen,
                            input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                            input logic [DATA_W-1:0] wdata);
    bif.core_req[ch]                      = req;
    bif.core_wen[ch]                      = wen;
    bif.core_add[ch*ADDR_W +: ADDR_W]     = addr;
    bif.core_be[ch*BE_W +: BE_W]          = be;
    bif.core_wdata[ch*DATA_W +: DATA_W]   = wdata;
  endtask

  task automatic send_rsp(input int ch, input logic [DATA_W-1:0] data);
    bif.bus_rvalid[ch]                   = 1'b1;
    bif.bus_rdata[ch*DATA_W +: DATA_W]   = data;
    exp_q.push_back({2'(ch), data});
  endtask

  task automatic clear_rsp();
    bif.bus_rvalid = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d;

    rst_n          = 1'b0;
    stop_req       = 1'b0;
    bif.core_req   = '0;
    bif.core_add   = '0;
    bif.core_wen   = '1;
    bif.core_be    = '0;
    bif.core_wdata = '0;
    bif.bus_gnt    = '0;
    bif.bus_rdata  = '0;
    bif.bus_rvalid = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stop_ack", 64'(stop_ack), 64'd0);
    check("rst_err",      64'(err),      64'd0);
    check("rst_state",    64'(state),    64'(RUN));
    check("rst_cnt",      64'(dbg_cnt),  64'd0);
    check("rst_bus_req",  64'(bif.bus_req), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- ch0 read, grant after 2 cycles, rvalid 1 cycle later ----
    a0 = 32'h0000_0100;
    cyc(); drive_core(0, 1'b1, 1'b1, a0, 4'hF, 32'h0);
    #1;
    check("t1_req_c0", 64'(bif.bus_req[0]), 64'd1);
    check("t1_gnt_c0", 64'(bif.core_gnt[0]), 64'd0);
    cyc(); #1;
    check("t1_req_c1", 64'(bif.bus_req[0]), 64'd1);
    check("t1_addr_c1", 64'(bif.bus_addr[0 +: ADDR_W]), 64'(a0));
    cyc(); bif.bus_gnt[0] = 1'b1; #1;
    check("t1_req_c2", 64'(bif.bus_req[0]), 64'd1);
    check("t1_gnt_c2", 64'(bif.core_gnt[0]), 64'd1);
    check("t1_we",     64'(bif.bus_we[0]), 64'd0);
    cyc(); drive_core(0, 1'b0, 1'b1, a0, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b0;
    send_rsp(0, 32'hDEADBEEF); #1;
    check("t1_cnt_1", 64'(cnt_of(0)), 64'd1);
`ifdef CGRA_OBI_RSP_REG_EN
    check("t1_rvalid_now", 64'(bif.core_rvalid[0]), 64'd0);
`else
    check("t1_rvalid_now", 64'(bif.core_rvalid[0]), 64'd1);
`endif
    cyc(); clear_rsp(); #1;
    check("t1_cnt_0", 64'(cnt_of(0)), 64'd0);
`ifdef CGRA_OBI_RSP_REG_EN
    check("t1_rvalid_late", 64'(bif.core_rvalid[0]), 64'd1);
`else
    check("t1_rvalid_late", 64'(bif.core_rvalid[0]), 64'd0);
`endif

    // ---- credit limit: gnt every cycle, no rvalid ----
    cyc(); drive_core(0, 1'b1, 1'b1, 32'h200, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b1; #1;
    check("t2_gnt_a", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); #1;
    check("t2_gnt_b", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); #1;
    check("t2_cnt_max", 64'(cnt_of(0)), 64'(MAX_OUTST));
    check("t2_req_blocked", 64'(bif.bus_req[0]), 64'd0);
    check("t2_gnt_blocked", 64'(bif.core_gnt[0]), 64'd0);
    cyc(); send_rsp(0, 32'h1111_1111); #1;
    check("t2_req_rsp_cyc", 64'(bif.bus_req[0]), 64'd0);
    cyc(); clear_rsp(); #1;
    check("t2_req_reissue", 64'(bif.bus_req[0]), 64'd1);
    check("t2_gnt_reissue", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); drive_core(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[0] = 1'b0;
    send_rsp(0, 32'h2222_2222);
    cyc(); send_rsp(0, 32'h3333_3333);
    cyc(); clear_rsp(); #1;
    check("t2_cnt_drained", 64'(cnt_of(0)), 64'd0);

    // ---- ch1 write, same-cycle gnt + rvalid at cnt=1 ----
    d = 32'hCAFE_0001;
    cyc(); drive_core(1, 1'b1, 1'b0, 32'h400, 4'h3, d); bif.bus_gnt[1] = 1'b1; #1;
    check("t3_we",    64'(bif.bus_we[1]), 64'd1);
    check("t3_be",    64'(bif.bus_be[BE_W +: BE_W]), 64'h3);
    check("t3_wdata", 64'(bif.bus_wdata[DATA_W +: DATA_W]), 64'(d));
    cyc(); send_rsp(1, 32'hA5A5_0001); #1;
    check("t3_gnt_overlap", 64'(bif.core_gnt[1]), 64'd1);
    cyc(); drive_core(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[1] = 1'b0; clear_rsp(); #1;
    check("t3_cnt_hold", 64'(cnt_of(1)), 64'd1);
    check("t3_err",      64'(err[1]), 64'd0);
    cyc(); send_rsp(1, 32'hA5A5_0002);
    cyc(); clear_rsp(); #1;
    check("t3_cnt_0", 64'(cnt_of(1)), 64'd0);

    // ---- ch2 unexpected rvalid ----
    check("t4_err_pre", 64'(err[2]), 64'd0);
    cyc(); send_rsp(2, 32'hBAD0_0002);
    cyc(); clear_rsp(); #1;
    check("t4_err_set", 64'(err[2]), 64'd1);
    check("t4_cnt_sat", 64'(cnt_of(2)), 64'd0);
    repeat (3) cyc();
    #1;
    check("t4_err_sticky", 64'(err[2]), 64'd1);

    // ---- drain / stop with a held request ----
    cyc(); drive_core(0, 1'b1, 1'b1, 32'h500, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b1;
    cyc(); bif.bus_gnt[0] = 1'b0;
    cyc(); stop_req = 1'b1; #1;
    check("t5_cnt_1", 64'(cnt_of(0)), 64'd1);
    check("t5_req_held", 64'(bif.bus_req[0]), 64'd1);
    cyc(); bif.bus_gnt[0] = 1'b1; #1;
    check("t5_state_drain", 64'(state), 64'(DRAIN));
    check("t5_gnt_in_drain", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); drive_core(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[0] = 1'b0;
    send_rsp(0, 32'h5555_0001); #1;
    check("t5_ack_busy", 64'(stop_ack), 64'd0);
    cyc(); send_rsp(0, 32'h5555_0002);
    cyc(); clear_rsp(); #1;
    check("t5_ack_g", 64'(stop_ack), 64'd0);
`ifdef CGRA_OBI_RSP_REG_EN
    cyc(); #1;
    check("t5_ack_rspreg", 64'(stop_ack), 64'd0);
`endif
    cyc(); #1;
    check("t5_ack_up", 64'(stop_ack), 64'd1);
    check("t5_state_stopped", 64'(state), 64'(STOPPED));
    cyc(); drive_core(0, 1'b1, 1'b1, 32'h600, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b1; #1;
    check("t5_req_stopped", 64'(bif.bus_req[0]), 64'd0);
    check("t5_gnt_stopped", 64'(bif.core_gnt[0]), 64'd0);
    cyc(); stop_req = 1'b0; #1;
    check("t5_ack_hold", 64'(stop_ack), 64'd1);
    check("t5_gnt_hold", 64'(bif.core_gnt[0]), 64'd0);
    cyc(); #1;
    check("t5_ack_down", 64'(stop_ack), 64'd0);
    check("t5_gnt_resume", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); drive_core(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[0] = 1'b0;
    send_rsp(0, 32'h6666_0001);
    cyc(); clear_rsp(); #1;
    check("t5_cnt_0", 64'(cnt_of(0)), 64'd0);

    // ---- async reset mid-transaction ----
    cyc(); drive_core(0, 1'b1, 1'b1, 32'h700, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b1;
    cyc();
    cyc(); #1;
    check("t6_cnt_2", 64'(cnt_of(0)), 64'd2);
    drive_core(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_cnt_rst",   64'(dbg_cnt), 64'd0);
    check("t6_err_rst",   64'(err), 64'd0);
    check("t6_ack_rst",   64'(stop_ack), 64'd0);
    check("t6_state_rst", 64'(state), 64'(RUN));
    check("t6_busreq_rst", 64'(bif.bus_req), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(); drive_core(0, 1'b1, 1'b1, 32'h800, 4'hF, 32'h0); bif.bus_gnt[0] = 1'b1; #1;
    check("t6_gnt_after", 64'(bif.core_gnt[0]), 64'd1);
    cyc(); drive_core(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0); bif.bus_gnt[0] = 1'b0; #1;
    check("t6_cnt_after", 64'(cnt_of(0)), 64'd1);
    send_rsp(0, 32'h7777_0001);
    cyc(); clear_rsp();
    repeat (3) cyc();
    #1;
    check("t6_cnt_final", 64'(cnt_of(0)), 64'd0);
    check("rsp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cgra_obi_master_bridge.md
Name: cgra_obi_master_bridge

Overview:
- Parametrised N-channel bridge between the CGRA column TCDM-style master ports (active-low write enable) and OBI master ports.
- Adds per-channel outstanding-transaction credit limiting and OBI address-phase hold tracking.
- Adds a global drain/stop handshake so the CGRA logic clock can be gated only when the fabric is quiescent.
- Sits between the CGRA core and the system bus, replacing the direct per-column combinational mapping.

Parameters:
- N_CH, 4, number of master channels (one per CGRA column).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MAX_OUTST, 2, maximum granted-but-unanswered transactions per channel (1..7).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  N_CH  per-channel request.
- core_add_i  in  N_CH*ADDR_W  per-channel address.
- core_wen_i  in  N_CH  per-channel write enable, active-low (0 = write).
- core_be_i  in  N_CH*DATA_W/8  byte enables.
- core_wdata_i  in  N_CH*DATA_W  write data.
- core_gnt_o  out  N_CH  grant to core.
- core_rdata_o  out  N_CH*DATA_W  response data.
- core_rvalid_o  out  N_CH  response valid.
- bus_req_o  out  N_CH  OBI req.
- bus_addr_o  out  N_CH*ADDR_W  OBI addr.
- bus_we_o  out  N_CH  OBI we (= ~core_wen_i).
- bus_be_o  out  N_CH*DATA_W/8  OBI be.
- bus_wdata_o  out  N_CH*DATA_W  OBI wdata.
- bus_gnt_i  in  N_CH  OBI gnt.
- bus_rdata_i  in  N_CH*DATA_W  OBI rdata.
- bus_rvalid_i  in  N_CH  OBI rvalid.
- stop_req_i  in  1  request to quiesce before clock gating.
- stop_ack_o  out  1  fabric quiescent; safe to gate.
- err_o  out  N_CH  sticky: rvalid received with zero outstanding.

Behaviour:
- Reset values: all outstanding counters 0, pending flags 0, FSM in RUN, stop_ack_o 0, err_o 0, and all registered outputs 0.
- Per channel, cnt counts 0..MAX_OUTST. pend = bus_req_o high last cycle without gnt.
- Issue gating:
  - can_issue = (cnt < MAX_OUTST) & (state == RUN).
  - bus_req_o = core_req_i & (can_issue | pend).
  - A request already presented is held until granted, per the OBI stability rule. Drain never withdraws it.
- Address-phase signals (addr, we, be, wdata) are combinational copies of the core inputs.
- core_gnt_o = bus_req_o & bus_gnt_i.
- cnt update:
  - +1 on a handshake (bus_req_o & bus_gnt_i).
  - -1 on bus_rvalid_i.
  - Simultaneous handshake and rvalid: cnt unchanged.
  - Response latency 0 is legal: gnt and rvalid in the same cycle with cnt == 0 is not an error.
  - rvalid with cnt == 0 and no same-cycle handshake: set err_o[ch] (sticky until reset), cnt stays 0 (saturates, no wrap).
- pend is set when bus_req_o & ~bus_gnt_i, and cleared on gnt.
- Response path: core_rdata_o/core_rvalid_o are a combinational pass-through of the bus response.
- FSM:
  - RUN: stop_req_i -> DRAIN.
  - DRAIN: ~stop_req_i -> RUN. Else, all cnt == 0, no pend, and response stage empty -> STOPPED.
  - STOPPED: ~stop_req_i -> RUN.
- stop_ack_o is registered: 1 only while in STOPPED. It falls in the cycle after stop_req_i deasserts, together with the return to RUN.
- Core requests arriving in DRAIN/STOPPED wait with gnt = 0 and are not lost.

Optional Feature:
- Macro CGRA_OBI_RSP_REG_EN.
- Defined:
  - Per-channel response register; core_rvalid_o and core_rdata_o are delayed by one cycle.
  - rdata is captured only when rvalid is high.
  - The register counts as non-empty for the STOPPED transition.
- Undefined: combinational pass-through as above.
- Counter behaviour is identical in both builds.

Decomposition:
- cgra_pkg holds:
  - bridge FSM enum (RUN, DRAIN, STOPPED);
  - default N_CH (= N_COL), ADDR_W, DATA_W;
  - MAX_OUTST constant;
  - the counter width derived as $clog2(MAX_OUTST+1).
- Sub-module cgra_obi_chan, instantiated N_CH times, holds:
  - cnt, pend, err;
  - the optional response register;
  - an idle output.
- The top holds the FSM and the AND-reduction of channel idles.

Test Plan:
- Ch0 read, gnt after 2 cycles, rvalid 1 cycle later, rdata 0xDEADBEEF -> bus_req held stable 3 cycles, core_gnt 1 cycle, core_rvalid with 0xDEADBEEF (+1 cycle with macro), cnt returns to 0.
- MAX_OUTST=2, gnt every cycle, no rvalid -> two grants, then bus_req_o low with core_req_i high. One rvalid -> third request issued the next cycle.
- Ch1 write, core_wen_i=0, be=0x3 -> bus_we_o=1, bus_be_o=0x3. Same-cycle gnt and rvalid at cnt=1 -> cnt stays 1, err_o=0.
- Ch2 rvalid with cnt=0 and no handshake -> err_o[2]=1 next cycle, stays 1 until rst_ni low, cnt stays 0.
- stop_req_i while ch0 has pend and cnt=1 -> request still granted. stop_ack_o rises 1 cycle after the last rvalid is consumed. A new core_req in STOPPED gets no gnt. Deassert stop_req_i -> stop_ack_o 0 and the request is granted.
- Assert rst_ni low mid-transaction with cnt=2 -> all outputs 0 immediately (asynchronously), FSM in RUN, and requests resume normally after release.
